// File: rtl/bin2seg9.sv
// -----------------------------------------------------------------------------
// bin2seg9 - binary to nine-digit 7-segment formatter
//
// Purpose:
//   Converts an unsigned binary value into NDIG 7-segment digit bytes packed
//   as data_pack for the downstream ctl_7seg9 display controller. The
//   conversion uses a sequential double-dabble, one shift per clock. It then
//   uses a single encode cycle to register every byte at once. data_pack only
//   changes at that encode edge, so a free-running display refresh never
//   shows a half-finished result.
//
// Ports:
//   clk        in   1        system clock, posedge
//   rst_n      in   1        asynchronous active-low reset
//   value      in   VAL_W    unsigned binary value to display
//   start      in   1        one-cycle request; value/blank_lz/dp_mask sampled
//   blank_lz   in   1        1 = blank leading zeros (units digit never blanked)
//   dp_mask    in   NDIG     bit i lights the decimal point of digit i
//   data_pack  out  8*NDIG   byte i = data_pack[8i+7:8i]; bit0=a..bit6=g, bit7=dp
//                            byte 0 = most significant digit
//   busy       out  1        conversion in progress; start ignored while high
//   done       out  1        one-cycle pulse when a new data_pack is valid
//   overflow   out  1        last completed conversion exceeded 10^NDIG-1
// -----------------------------------------------------------------------------
module bin2seg9 #(
    parameter int          NDIG    = 9,
    parameter int          VAL_W   = 30,
    parameter logic [7:0]  OVF_SEG = 8'h40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VAL_W-1:0]    value,
    input  logic                start,
    input  logic                blank_lz,
    input  logic [NDIG-1:0]     dp_mask,
    output logic [8*NDIG-1:0]   data_pack,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VAL_W - 1);

    // Largest value representable in NDIG decimal digits, 10^NDIG - 1.
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_decimal(NDIG);

    // Decimal digit to segments a..g (bit0 = a). Non-decimal codes show nothing.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_ENC  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [VAL_W-1:0]       shreg_r;
    logic [BCD_W-1:0]       bcd_r;
    logic [BCD_W-1:0]       bcd_adj_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   blank_r;
    logic [NDIG-1:0]        dp_r;
    logic                   ovf_next_r;
    logic                   ovf_in_s;
    logic [8*NDIG-1:0]      enc_s;

    logic [8*NDIG-1:0]      data_pack_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   overflow_r;

    assign data_pack = data_pack_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

    // Range check on the incoming value, zero-extended to the constant's width.
    assign ovf_in_s = (64'(value) > MAX_DEC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> CONV (VAL_W shifts) -> ENC -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CONV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = ST_ENC;
                end else begin
                    state_next_s = ST_CONV;
                end
            end
            ST_ENC: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj_s = '0;
        for (int n = 0; n < NDIG; n++) begin
            if (bcd_r[4*n +: 4] >= 4'd5) begin
                bcd_adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*n +: 4] = bcd_r[4*n +: 4];
            end
        end
    end

    // Segment encoder over the finished BCD result. Byte 0 is the most
    // significant digit, so the scan runs from the top nibble downwards and
    // blanks zeros until the first nonzero digit. The units digit is always
    // shown. Decimal points are applied regardless of blanking or overflow.
    always_comb begin
        logic       lead_s;
        logic [3:0] digit_s;
        logic [6:0] seg_s;
        enc_s   = '0;
        lead_s  = 1'b1;
        digit_s = 4'd0;
        seg_s   = 7'd0;
        for (int i = 0; i < NDIG; i++) begin
            digit_s = bcd_r[4*(NDIG-1-i) +: 4];
            if (ovf_next_r) begin
                seg_s = OVF_SEG[6:0];
            end else if (blank_r && lead_s && (digit_s == 4'd0) && (i != NDIG-1)) begin
                seg_s = 7'd0;
            end else begin
                seg_s = seg7(digit_s);
            end
            if (digit_s != 4'd0) begin
                lead_s = 1'b0;
            end else begin
                lead_s = lead_s;
            end
            enc_s[8*i +: 8] = {dp_r[i], seg_s};
        end
    end

    // Datapath and registered outputs. done is a one-cycle pulse, so it
    // defaults low every edge and is only raised in ENC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r     <= '0;
            bcd_r       <= '0;
            cnt_r       <= '0;
            blank_r     <= 1'b0;
            dp_r        <= '0;
            ovf_next_r  <= 1'b0;
            data_pack_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shreg_r    <= value;
                        bcd_r      <= '0;
                        cnt_r      <= '0;
                        blank_r    <= blank_lz;
                        dp_r       <= dp_mask;
                        ovf_next_r <= ovf_in_s;
                        busy_r     <= 1'b1;
                    end
                end
                ST_CONV: begin
                    // {bcd, shreg} shifted left once, using the corrected nibbles.
                    bcd_r   <= {bcd_adj_s[BCD_W-2:0], shreg_r[VAL_W-1]};
                    shreg_r <= {shreg_r[VAL_W-2:0], 1'b0};
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_ENC: begin
                    data_pack_r <= enc_s;
                    overflow_r  <= ovf_next_r;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2seg9.sv
// -----------------------------------------------------------------------------
// tb_bin2seg9 - self-checking bench for bin2seg9
//
// The driver pushes the expected data_pack/overflow for each accepted request
// into a queue; a monitor pops and compares on every done pulse. A done pulse
// with nothing queued is reported as an error. Expected bytes come from a
// decimal model using divide/modulo.
// -----------------------------------------------------------------------------
module tb_bin2seg9;

    localparam int NDIG  = 9;
    localparam int VAL_W = 30;

    logic                clk;
    logic                rst_n;
    logic [VAL_W-1:0]    value;
    logic                start;
    logic                blank_lz;
    logic [NDIG-1:0]     dp_mask;
    logic [8*NDIG-1:0]   data_pack;
    logic                busy;
    logic                done;
    logic                overflow;

    typedef struct {
        logic [8*NDIG-1:0] pack;
        logic              ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    bin2seg9 #(.NDIG(NDIG), .VAL_W(VAL_W), .OVF_SEG(8'h40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .start     (start),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .data_pack (data_pack),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    // Decimal reference model of the packed display bytes.
    function automatic logic [71:0] model_pack(input longint v, input bit blz, input logic [8:0] dp);
        logic [71:0] r;
        bit          lead;
        longint      p;
        int          d;
        r    = '0;
        lead = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v > 64'd999999999) begin
                r[8*i +: 8] = {dp[i], 7'h40};
            end else begin
                p = 1;
                for (int k = 0; k < NDIG-1-i; k++) p = p * 10;
                d = int'((v / p) % 10);
                if (d != 0) lead = 1'b0;
                if (blz && lead && (i != NDIG-1)) r[8*i +: 8] = {dp[i], 7'h00};
                else                              r[8*i +: 8] = {dp[i], seg_of(d)};
            end
        end
        return r;
    endfunction

    // Drive one start pulse (called #1 after a posedge) and queue the result.
    task automatic start_conv(input longint v, input bit blz, input logic [8:0] dp);
        exp_t e;
        value    = VAL_W'(v);
        blank_lz = blz;
        dp_mask  = dp;
        start    = 1'b1;
        e.pack   = model_pack(v, blz, dp);
        e.ovf    = (v > 64'd999999999);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", 72'(busy), 72'd1);
    endtask

    // Wait (bounded) for done; lat0 = edges already elapsed after E0.
    task automatic wait_done(input int lat0, input string tag);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 72'(lat), 72'd31);
        check_eq({tag, "_busy_done"}, 72'(busy), 72'd0);
    endtask

    // Scoreboard monitor: compare on each done pulse.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 72'd1, 72'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("data_pack", data_pack, e.pack);
                check_eq("overflow", 72'(overflow), 72'(e.ovf));
            end
        end
    end

    // Global watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        #22;
        check_eq("rst_data_pack", data_pack, 72'd0);
        check_eq("rst_busy", 72'(busy), 72'd0);
        check_eq("rst_done", 72'(done), 72'd0);
        check_eq("rst_overflow", 72'(overflow), 72'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Main value, plus a hand-derived pack (byte 0 = MSD at [7:0]).
        start_conv(123456789, 1'b0, 9'h000);
        wait_done(0, "v123456789");
        check_eq("v123456789_literal", data_pack, 72'h6F_7F_07_7D_6D_66_4F_5B_06);

        start_conv(42, 1'b1, 9'h000);
        wait_done(0, "v42_blank");
        start_conv(42, 1'b0, 9'h000);
        wait_done(0, "v42_noblank");
        start_conv(0, 1'b1, 9'h100);
        wait_done(0, "v0_dp");
        check_eq("v0_units_byte", 72'(data_pack[71:64]), 72'hBF);

        // Overflow boundary.
        start_conv(1000000000, 1'b0, 9'h000);
        wait_done(0, "ovf");
        check_eq("ovf_hold", 72'(overflow), 72'd1);
        start_conv(999999999, 1'b1, 9'h0A5);
        wait_done(0, "max");

        // Start while busy is ignored; back-to-back start in the done cycle.
        start_conv(987654321, 1'b0, 9'h000);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        value = VAL_W'(7);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = VAL_W'(5);
        wait_done(5, "ignore");
        start_conv(1000, 1'b1, 9'h010);
        wait_done(0, "b2b");

        // Reset mid-conversion aborts with no done pulse.
        start_conv(55555, 1'b0, 9'h000);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("abort_data_pack", data_pack, 72'd0);
        check_eq("abort_busy", 72'(busy), 72'd0);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check_eq("abort_idle_busy", 72'(busy), 72'd0);
        start_conv(31415, 1'b1, 9'h000);
        wait_done(0, "after_abort");

        // Random values across the full input range.
        for (int n = 0; n < 8; n++) begin
            start_conv(longint'($urandom_range(0, 32'h3FFFFFFF)), 1'($urandom_range(0, 1)),
                       9'($urandom_range(0, 511)));
            wait_done(0, "random");
        end

        @(posedge clk);
        #1;
        check_eq("queue_empty", 72'(exp_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
